// File: rtl/matrix_xfade.sv
// matrix_xfade: N_IN x N_OUT audio routing matrix with per-output linear
// crossfades. Each sample_strobe captures in_bus, then CALC produces one
// output per cycle through a single shared signed multiplier. DONE commits
// all outputs together and pulses out_valid. Route changes are written
// through a valid/ready port, and each change starts a 2^XF_LOG2-sample fade.
//
// Ports
//   clk, resetn      : clock, asynchronous active-low reset
//   sample_strobe    : one-cycle pulse per audio sample
//   in_bus           : N_IN signed samples, channel k at [k*BITSIZE +: BITSIZE]
//   cfg_valid/ready  : select-write handshake (ready only in idle, no strobe)
//   cfg_out, cfg_sel : destination index and new source index
//   out_bus          : N_OUT routed samples, same packing as in_bus
//   out_valid        : one-cycle pulse when out_bus is updated
//   overrun, cfg_err : sticky flags (strobe while busy, bad destination)
module matrix_xfade #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 9,
  parameter int N_OUT   = 11,
  parameter int SELBITS = 4,
  parameter int XF_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     sample_strobe,
  input  logic [N_IN*BITSIZE-1:0]  in_bus,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [SELBITS-1:0]       cfg_out,
  input  logic [SELBITS-1:0]       cfg_sel,
  output logic [N_OUT*BITSIZE-1:0] out_bus,
  output logic                     out_valid,
  output logic                     overrun,
  output logic                     cfg_err
);

  localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int RW = XF_LOG2 + 1;
  // One guard bit above the worst-case |diff * ramp|
  localparam int PW = BITSIZE + XF_LOG2 + 3;

  localparam logic [RW-1:0]      RAMP_FULL = {1'b1, {XF_LOG2{1'b0}}};
  localparam logic [RW-1:0]      RAMP_ONE  = {{XF_LOG2{1'b0}}, 1'b1};
  localparam logic [SELBITS:0]   N_OUT_L   = (SELBITS+1)'(N_OUT);
  localparam logic [CW-1:0]      LAST_CH   = CW'(N_OUT - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [N_IN*BITSIZE-1:0] snap_q;
  logic [CW-1:0]           cnt_q;
  logic [SELBITS-1:0]      old_sel_q [N_OUT];
  logic [SELBITS-1:0]      new_sel_q [N_OUT];
  logic [RW-1:0]           ramp_q    [N_OUT];
  logic [BITSIZE-1:0]      stage_q   [N_OUT];
  logic [BITSIZE-1:0]      out_q     [N_OUT];
  logic                    out_valid_q;
  logic                    overrun_q;
  logic                    cfg_err_q;

  logic [SELBITS-1:0]      cur_old_sel_s;
  logic [SELBITS-1:0]      cur_new_sel_s;
  logic [RW-1:0]           cur_ramp_s;
  logic                    fading_s;
  logic [BITSIZE-1:0]      old_val_s;
  logic [BITSIZE-1:0]      new_val_s;
  logic signed [BITSIZE:0] diff_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [PW-1:0]    shift_s;
  logic signed [PW-1:0]    old_ext_s;
  logic [BITSIZE-1:0]      res_d;
  logic                    cfg_xfer_s;

  // Select values outside 0..N_IN-1 route a silent (zero) source
  function automatic logic [BITSIZE-1:0] pick_src(
    input logic [N_IN*BITSIZE-1:0] bus,
    input logic [SELBITS-1:0]      sel
  );
    logic [BITSIZE-1:0] v;
    v = '0;
    for (int k = 0; k < N_IN; k++) begin
      v = (sel == SELBITS'(k)) ? bus[k*BITSIZE +: BITSIZE] : v;
    end
    return v;
  endfunction

  assign cfg_ready  = (state_q == IDLE) && !sample_strobe;
  assign cfg_xfer_s = cfg_valid && cfg_ready;

  // Shared datapath: selects the channel under cnt_q and computes its sample
  always_comb begin
    cur_old_sel_s = '0;
    cur_new_sel_s = '0;
    cur_ramp_s    = '0;
    for (int j = 0; j < N_OUT; j++) begin
      cur_old_sel_s = (cnt_q == CW'(j)) ? old_sel_q[j] : cur_old_sel_s;
      cur_new_sel_s = (cnt_q == CW'(j)) ? new_sel_q[j] : cur_new_sel_s;
      cur_ramp_s    = (cnt_q == CW'(j)) ? ramp_q[j]    : cur_ramp_s;
    end
    fading_s  = (cur_old_sel_s != cur_new_sel_s);
    old_val_s = pick_src(snap_q, cur_old_sel_s);
    new_val_s = pick_src(snap_q, cur_new_sel_s);
    diff_s    = $signed({new_val_s[BITSIZE-1], new_val_s})
              - $signed({old_val_s[BITSIZE-1], old_val_s});
    // Ramp is unsigned, so zero-extend it before the signed multiply
    prod_s    = $signed({{(PW-BITSIZE-1){diff_s[BITSIZE]}}, diff_s})
              * $signed({{(PW-RW){1'b0}}, cur_ramp_s});
    shift_s   = prod_s >>> XF_LOG2;
    old_ext_s = $signed({{(PW-BITSIZE){old_val_s[BITSIZE-1]}}, old_val_s});
    if (fading_s) begin
      res_d = BITSIZE'(shift_s + old_ext_s);
    end else begin
      res_d = new_val_s;
    end
  end

  // Control FSM, route table, staging and committed outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        old_sel_q[j] <= '0;
        new_sel_q[j] <= '0;
        ramp_q[j]    <= '0;
        stage_q[j]   <= '0;
        out_q[j]     <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (sample_strobe && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_strobe) begin
            snap_q  <= in_bus;
            cnt_q   <= '0;
            state_q <= CALC;
          end else if (cfg_xfer_s) begin
            if ({1'b0, cfg_out} >= N_OUT_L) begin
              cfg_err_q <= 1'b1;
            end else begin
              for (int j = 0; j < N_OUT; j++) begin
                if (cfg_out == SELBITS'(j)) begin
                  if (old_sel_q[j] != new_sel_q[j]) begin
                    // Mid-fade: restart from the target we were heading to
                    old_sel_q[j] <= new_sel_q[j];
                    new_sel_q[j] <= cfg_sel;
                    ramp_q[j]    <= RAMP_ONE;
                  end else if (cfg_sel != new_sel_q[j]) begin
                    new_sel_q[j] <= cfg_sel;
                    ramp_q[j]    <= RAMP_ONE;
                  end
                end
              end
            end
          end
        end
        CALC: begin
          for (int j = 0; j < N_OUT; j++) begin
            if (cnt_q == CW'(j)) begin
              stage_q[j] <= res_d;
              if (fading_s) begin
                // ramp == 2^XF_LOG2 produced exactly the new source; fade ends
                if (ramp_q[j] == RAMP_FULL) begin
                  old_sel_q[j] <= new_sel_q[j];
                  ramp_q[j]    <= '0;
                end else begin
                  ramp_q[j] <= ramp_q[j] + RAMP_ONE;
                end
              end
            end
          end
          if (cnt_q == LAST_CH) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          out_q       <= stage_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_pack
    assign out_bus[g*BITSIZE +: BITSIZE] = out_q[g];
  end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_matrix_xfade.sv
// Self-checking bench for matrix_xfade: a table of steady routing vectors,
// then hand-written crossfade, restart, overrun, bad-destination and
// mid-calculation reset sequences. Expected buses go into a scoreboard queue
// when a strobe is driven and are compared when out_valid fires.
module tb_matrix_xfade;

  localparam int BITSIZE = 16;
  localparam int N_IN    = 9;
  localparam int N_OUT   = 11;
  localparam int SELBITS = 4;
  localparam int XF_LOG2 = 6;
  localparam int IW      = N_IN * BITSIZE;
  localparam int OW      = N_OUT * BITSIZE;

  logic               clk = 1'b0;
  logic               resetn;
  logic               sample_strobe;
  logic [IW-1:0]      in_bus;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [SELBITS-1:0] cfg_out;
  logic [SELBITS-1:0] cfg_sel;
  logic [OW-1:0]      out_bus;
  logic               out_valid;
  logic               overrun;
  logic               cfg_err;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [OW-1:0] sb_q[$];
  logic [OW-1:0] last_exp = '0;
  int            src [N_IN];
  int            ex  [N_OUT];

  typedef struct {
    int ch0;
    int exp_out;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  matrix_xfade #(
    .BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT),
    .SELBITS(SELBITS), .XF_LOG2(XF_LOG2)
  ) dut (
    .clk(clk), .resetn(resetn), .sample_strobe(sample_strobe),
    .in_bus(in_bus), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_out(cfg_out), .cfg_sel(cfg_sel), .out_bus(out_bus),
    .out_valid(out_valid), .overrun(overrun), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack_ex();
    logic [OW-1:0] r;
    for (int j = 0; j < N_OUT; j++) r[j*BITSIZE +: BITSIZE] = BITSIZE'(ex[j]);
    return r;
  endfunction

  task automatic apply_in();
    for (int k = 0; k < N_IN; k++) in_bus[k*BITSIZE +: BITSIZE] = BITSIZE'(src[k]);
  endtask

  task automatic set_ex_all(input int v);
    for (int j = 0; j < N_OUT; j++) ex[j] = v;
  endtask

  task automatic cfg_write(input int o, input int s);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_out   = SELBITS'(o);
    cfg_sel   = SELBITS'(s);
    #1;
    chk("cfg_ready_in_idle", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // One accepted strobe: push expected bus, wait for out_valid, compare
  task automatic do_strobe();
    int c;
    logic [OW-1:0] e;
    @(negedge clk);
    sample_strobe = 1'b1;
    sb_q.push_back(pack_ex());
    #1;
    chk("cfg_ready_low_with_strobe", cfg_ready, 0);
    c = 0;
    while (c < 40) begin
      @(posedge clk);
      #1;
      sample_strobe = 1'b0;
      if (out_valid) break;
      if (c == N_OUT) chk_bus("out_bus_hold", out_bus, last_exp);
      c++;
    end
    chk("strobe_to_valid_latency", c, N_OUT + 1);
    if (c < 40) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got out_valid, expected none");
      end else begin
        e = sb_q.pop_front();
        chk_bus("out_bus", out_bus, e);
        last_exp = e;
      end
      @(posedge clk);
      #1;
      chk("out_valid_pulse_width", out_valid, 0);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [OW-1:0] e;

    tbl[0] = '{1000, 1000};
    tbl[1] = '{-1, -1};
    tbl[2] = '{32767, 32767};
    tbl[3] = '{-32768, -32768};
    tbl[4] = '{0, 0};

    resetn        = 1'b0;
    sample_strobe = 1'b0;
    cfg_valid     = 1'b0;
    cfg_out       = '0;
    cfg_sel       = '0;
    in_bus        = '0;
    for (int k = 0; k < N_IN; k++) src[k] = k * 111 + 7;
    set_ex_all(0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_bus("reset_out_bus", out_bus, '0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_cfg_err", cfg_err, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("idle_cfg_ready", cfg_ready, 1);

    // Table: all outputs default to channel 0
    for (int i = 0; i < 5; i++) begin
      src[0] = tbl[i].ch0;
      apply_in();
      set_ex_all(tbl[i].exp_out);
      do_strobe();
    end

    // Fade out3 from ch0 (0) to ch2 (6400): 100, 200, ..., 6400 then steady
    src[0] = 0; src[1] = 11; src[2] = 6400;
    apply_in();
    set_ex_all(0);
    cfg_write(3, 2);
    for (int k = 1; k <= 64; k++) begin
      ex[3] = 100 * k;
      do_strobe();
    end
    ex[3] = 6400;
    do_strobe();
    do_strobe();

    // Full-scale fade on out5: -32768 -> 32767, no wrap
    src[0] = -32768; src[1] = 32767;
    apply_in();
    set_ex_all(-32768);
    ex[3] = 6400;
    cfg_write(5, 1);
    for (int k = 1; k <= 64; k++) begin
      ex[5] = -32768 + ((65535 * k) >>> XF_LOG2);
      do_strobe();
    end
    chk("neg_fade_final", longint'($signed(out_bus[5*BITSIZE +: BITSIZE])), 32767);
    ex[5] = 32767;
    do_strobe();

    // Restart: out3 2->4, then at sample 10 rewrite to silent select 15
    src[0] = 0; src[4] = 3200;
    apply_in();
    set_ex_all(0);
    ex[5] = 32767;
    cfg_write(3, 4);
    for (int k = 1; k <= 10; k++) begin
      ex[3] = 6400 + (((3200 - 6400) * k) >>> XF_LOG2);
      do_strobe();
    end
    cfg_write(3, 15);
    for (int k = 1; k <= 64; k++) begin
      ex[3] = 3200 + ((-3200 * k) >>> XF_LOG2);
      do_strobe();
    end
    ex[3] = 0;
    do_strobe();

    // Bad destination: accepted, flagged, routing unchanged
    cfg_write(12, 2);
    chk("cfg_err_set", cfg_err, 1);
    do_strobe();

    // Strobe during CALC: ignored, overrun set, single out_valid
    @(negedge clk);
    sample_strobe = 1'b1;
    sb_q.push_back(pack_ex());
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    chk("cfg_ready_low_in_calc", cfg_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample_strobe = 1'b1;
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk_bus("overrun_out_bus", out_bus, e);
          last_exp = e;
        end
      end
    end
    chk("overrun_single_valid", pulses, 1);
    chk("overrun_set", overrun, 1);
    chk("cfg_err_sticky", cfg_err, 1);

    // Reset mid-CALC
    @(negedge clk);
    sample_strobe = 1'b1;
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_bus("midcalc_reset_out_bus", out_bus, '0);
    chk("midcalc_reset_out_valid", out_valid, 0);
    chk("midcalc_reset_overrun", overrun, 0);
    chk("midcalc_reset_cfg_err", cfg_err, 0);
    last_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("midcalc_no_pending_valid", pulses, 0);

    // Routing back to default after reset
    src[0] = -5;
    apply_in();
    set_ex_all(-5);
    do_strobe();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_xfade.md
MATRIX_XFADE -- requirements
Module: matrix_xfade

Interface
REQ-001 SHALL have parameter BITSIZE, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter N_IN, default 9: number of routable source channels.
REQ-003 SHALL have parameter N_OUT, default 11: number of destination channels.
REQ-004 SHALL have parameter SELBITS, default 4: select field width, with 2^SELBITS >= N_IN+1.
REQ-005 SHALL have parameter XF_LOG2, default 6: crossfade length of 2^XF_LOG2 samples.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port sample_strobe, input, 1: one-cycle pulse per audio sample.
REQ-009 SHALL have port in_bus, input, N_IN*BITSIZE: source samples, channel k at bits [k*BITSIZE +: BITSIZE].
REQ-010 SHALL have port cfg_valid, input, 1: select-write request.
REQ-011 SHALL have port cfg_ready, output, 1: select-write accept.
REQ-012 SHALL have port cfg_out, input, SELBITS: destination index.
REQ-013 SHALL have port cfg_sel, input, SELBITS: source index for that destination.
REQ-014 SHALL have port out_bus, output, N_OUT*BITSIZE: routed samples, same packing as in_bus.
REQ-015 SHALL have port out_valid, output, 1: one-cycle pulse when out_bus is updated.
REQ-016 SHALL have port overrun, output, 1: sticky flag for a strobe arriving while busy.
REQ-017 SHALL have port cfg_err, output, 1: sticky flag for a write with cfg_out >= N_OUT.

Function
REQ-018 SHALL per output j hold old_sel[j], new_sel[j] and ramp[j] (XF_LOG2+1 bits); channel j is fading when old_sel[j] != new_sel[j].
REQ-019 SHALL treat a select value >= N_IN as a silent source of value 0.
REQ-020 SHALL implement FSM states IDLE, CALC and DONE.
REQ-021 SHALL on sample_strobe in IDLE capture in_bus into a snapshot register, clear the channel counter and enter CALC.
REQ-022 SHALL in CALC process exactly one output per cycle, j = 0..N_OUT-1, using one shared signed multiplier.
REQ-023 SHALL set output j to snap[new_sel[j]] when channel j is not fading.
REQ-024 SHALL set output j to old + ((new - old) * ramp[j]) >>> XF_LOG2 when channel j is fading, with diff (BITSIZE+1) bits, full-width product and arithmetic shift, then truncate to BITSIZE.
REQ-025 SHALL on a fading channel increment ramp[j] after its calculation; when ramp reaches 2^XF_LOG2 it SHALL set old_sel[j] <= new_sel[j] and ramp[j] <= 0.
REQ-026 SHALL make the result exactly equal to the new source on the final fade sample.
REQ-027 SHALL after output N_OUT-1 enter DONE, commit all outputs to out_bus together, pulse out_valid for 1 cycle and return to IDLE.
REQ-028 SHALL give a latency of N_OUT+1 cycles from sample_strobe to out_valid, and SHALL not change out_bus at any other time.
REQ-029 SHALL on sample_strobe in CALC or DONE ignore the strobe and set overrun.
REQ-030 SHALL drive cfg_ready = 1 only in IDLE with no sample_strobe in that same cycle; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-031 SHALL on a transfer to a non-fading channel set new_sel <= cfg_sel and ramp <= 1, unless cfg_sel equals the current select, in which case it SHALL do nothing.
REQ-032 SHALL on a transfer to a fading channel set old_sel <= prior new_sel, new_sel <= cfg_sel and ramp <= 1, restarting the fade.
REQ-033 SHALL on a transfer with cfg_out >= N_OUT accept the write, change no state and set cfg_err.

Reset
REQ-034 SHALL while resetn = 0 clear all old_sel, new_sel and ramp to 0, out_bus to 0, out_valid, overrun and cfg_err to 0, and put the FSM in IDLE.
REQ-035 SHALL on reset asserted mid-CALC discard the partial sample and leave no out_valid pulse pending.
REQ-036 SHALL have overrun and cfg_err clear only on reset.

Verification
REQ-037 SHALL cover: reset, in_bus ch0=1000, one strobe -> all outputs 1000, out_valid exactly N_OUT+1 cycles after strobe, pulse 1 cycle.
REQ-038 SHALL cover: write out3 <- ch2 (ch0=0, ch2=6400), XF_LOG2=6 -> out3 = 100, 200, ..., 6400 over 64 strobes, then steady 6400.
REQ-039 SHALL cover: negative fade ch0=-32768 to ch1=32767 -> no wrap, monotonic, final value 32767.
REQ-040 SHALL cover: a second write to out3 at fade sample 10 -> fade restarts from the prior target with ramp=1; a select of 15 yields 0.
REQ-041 SHALL cover: strobe during CALC -> overrun=1, no extra out_valid; a write with cfg_out=12 -> cfg_err=1 and routing unchanged.
REQ-042 SHALL cover: resetn low mid-CALC -> out_bus=0, no out_valid, overrun=0.
